// File: rtl/vector_loader.sv
// Loads consecutive vector registers from byte-wide pixel memory, packing four
// pixels little-endian into each 32-bit word written through the WE_V/DirV/DinV port.
module vector_loader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [3:0]        dst_reg,
  input  logic [4:0]        num_words,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              WE_V,
  output logic [3:0]        DirV,
  output logic [31:0]       DinV,
  output logic              busy,
  output logic              done
);

  // The fetch/capture schedule assumes read data one cycle after the strobe.
  if (LAT != 1) begin : gBadLat
    $error("vector_loader supports LAT == 1 only");
  end

  typedef enum logic [2:0] {StIdle, StFetch, StLast, StWrite, StFin} stateT;

  stateT             stateQ, stateD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [1:0]        bQ, bD;
  logic [3:0]        regQ, regD;
  logic [4:0]        remQ, remD;
  logic [31:0]       packQ, packD;
  logic [4:0]        numClamp;

  logic              memRdD, weD, busyD, doneD;
  logic [ADDR_W-1:0] memAddrD;
  logic [3:0]        dirD;
  logic [31:0]       dinD;

  assign numClamp = (num_words > 5'd16) ? 5'd16 : num_words;

  always_comb begin
    stateD   = stateQ;
    addrD    = addrQ;
    bD       = bQ;
    regD     = regQ;
    remD     = remQ;
    packD    = packQ;
    memAddrD = mem_addr;
    dirD     = DirV;
    dinD     = DinV;

    unique case (stateQ)
      StIdle: begin
        if (start) begin
          regD     = dst_reg;
          remD     = numClamp;
          bD       = 2'd0;
          memAddrD = base_addr;
          addrD    = base_addr + ADDR_W'(1);
          stateD   = (numClamp == 5'd0) ? StFin : StFetch;
        end
      end
      StFetch: begin
        // Data arriving now belongs to the byte issued in the previous cycle.
        if (bQ != 2'd0) packD[8*(int'(bQ) - 1) +: 8] = mem_data;
        if (bQ == 2'd3) begin
          stateD = StLast;
        end else begin
          bD       = bQ + 2'd1;
          memAddrD = addrQ;
          addrD    = addrQ + ADDR_W'(1);
        end
      end
      StLast: begin
        packD[31:24] = mem_data;
        dirD         = regQ;
        dinD         = {mem_data, packQ[23:0]};
        stateD       = StWrite;
      end
      StWrite: begin
        regD = regQ + 4'd1;
        remD = remQ - 5'd1;
        if (remQ > 5'd1) begin
          stateD   = StFetch;
          bD       = 2'd0;
          memAddrD = addrQ;
          addrD    = addrQ + ADDR_W'(1);
        end else begin
          stateD = StFin;
        end
      end
      StFin:   stateD = StIdle;
      default: stateD = StIdle;
    endcase

    // Outputs are registered, so decode them from the state being entered.
    memRdD = (stateD == StFetch);
    weD    = (stateD == StWrite);
    doneD  = (stateD == StFin);
    busyD  = (stateD != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= StIdle;
      addrQ    <= '0;
      bQ       <= '0;
      regQ     <= '0;
      remQ     <= '0;
      packQ    <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      WE_V     <= 1'b0;
      DirV     <= '0;
      DinV     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      addrQ    <= addrD;
      bQ       <= bD;
      regQ     <= regD;
      remQ     <= remD;
      packQ    <= packD;
      mem_rd   <= memRdD;
      mem_addr <= memAddrD;
      WE_V     <= weD;
      DirV     <= dirD;
      DinV     <= dinD;
      busy     <= busyD;
      done     <= doneD;
    end
  end

endmodule
